// File: rtl/hog_pkg.sv
// Shared defaults and block-index helper for the HOG block assembler.
package hog_pkg;

  localparam int NBIN_DEF  = 9;
  localparam int BIN_W_DEF = 32;

  // Raster index of the 2x2 block whose bottom-right cell sits at (cx, cy).
  function automatic int hog_bid(input int cx, input int cy, input int cells_x);
    return (cy - 1) * (cells_x - 1) + (cx - 1);
  endfunction

endpackage

// File: rtl/hog_line_buf.sv
// Single-row cell buffer: asynchronous read and synchronous write, so a
// same-cycle read at the write address returns the old entry.
module hog_line_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 288,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/hog_block_assembler.sv
// Assembles 2x2 cell blocks from a raster stream of cell histograms.
// Optional HOG_BLOCK_OVF_EN adds a sticky o_ovf input-stall flag.
module hog_block_assembler
  import hog_pkg::*;
#(
  parameter int NBIN    = NBIN_DEF,
  parameter int BIN_W   = BIN_W_DEF,
  parameter int CELLS_X = 16,
  parameter int CELLS_Y = 12,
  parameter int BID_W   = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic                  i_sof,
  input  logic [NBIN*BIN_W-1:0] i_bin,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [BID_W-1:0]      bid,
  output logic [NBIN*BIN_W-1:0] fea_a,
  output logic [NBIN*BIN_W-1:0] fea_b,
  output logic [NBIN*BIN_W-1:0] fea_c,
  output logic [NBIN*BIN_W-1:0] fea_d
`ifdef HOG_BLOCK_OVF_EN
  ,
  output logic                  o_ovf
`endif
);

  localparam int W    = NBIN * BIN_W;
  localparam int CX_W = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
  localparam int CY_W = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;

  logic [CX_W-1:0]  cx, ecx, cx_nxt;
  logic [CY_W-1:0]  cy, ecy, cy_nxt;
  logic [W-1:0]     left, upleft, rb_rd;
  logic [BID_W-1:0] bid_nxt;
  logic             acc, emit;

  assign i_ready = !o_valid || o_ready;
  assign acc     = i_valid && i_ready;

  // i_sof forces the accepted cell to (0,0) whatever the counters say.
  always_comb begin
    ecx    = i_sof ? '0 : cx;
    ecy    = i_sof ? '0 : cy;
    cx_nxt = ecx + 1'b1;
    cy_nxt = ecy;
    if (ecx == CX_W'(CELLS_X - 1)) begin
      cx_nxt = '0;
      cy_nxt = (ecy == CY_W'(CELLS_Y - 1)) ? '0 : ecy + 1'b1;
    end
  end

  assign emit    = acc && (ecx != '0) && (ecy != '0);
  assign bid_nxt = BID_W'(hog_bid(int'(ecx), int'(ecy), CELLS_X));

  hog_line_buf #(
    .DEPTH (CELLS_X),
    .WIDTH (W),
    .AW    (CX_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (acc),
    .waddr (ecx),
    .wdata (i_bin),
    .raddr (ecx),
    .rdata (rb_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cx     <= '0;
      cy     <= '0;
      left   <= '0;
      upleft <= '0;
    end else if (acc) begin
      cx     <= cx_nxt;
      cy     <= cy_nxt;
      left   <= i_bin;
      upleft <= rb_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      bid     <= '0;
      fea_a   <= '0;
      fea_b   <= '0;
      fea_c   <= '0;
      fea_d   <= '0;
    end else if (emit) begin
      o_valid <= 1'b1;
      bid     <= bid_nxt;
      fea_a   <= upleft;
      fea_b   <= rb_rd;
      fea_c   <= left;
      fea_d   <= i_bin;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef HOG_BLOCK_OVF_EN
  logic [5:0] stall_cnt;

  // Flag on the 64th consecutive cycle of a refused cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      o_ovf     <= 1'b0;
    end else if (i_valid && !i_ready) begin
      if (stall_cnt == 6'd63) o_ovf <= 1'b1;
      else                    stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end
`endif

endmodule

// File: doc/hog_block_assembler.md
HOG_BLOCK_ASSEMBLER -- requirements
Module: hog_block_assembler

Interface
REQ-001 SHALL have parameter NBIN, default 9: histogram bins per cell.
REQ-002 SHALL have parameter BIN_W, default 32: bits per bin (unsigned).
REQ-003 SHALL have parameter CELLS_X, default 16: cells per row, >=2.
REQ-004 SHALL have parameter CELLS_Y, default 12: cell rows per frame, >=2.
REQ-005 SHALL have parameter BID_W, default 13: block id width, with (CELLS_X-1)*(CELLS_Y-1) <= 2^BID_W.
REQ-006 clk  input  1  sole clock; all logic on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 i_valid  input  1  cell histogram valid.
REQ-009 i_ready  output  1  block accepts cell.
REQ-010 i_sof  input  1  qualifies first cell of a frame; sampled only when i_valid.
REQ-011 i_bin  input  NBIN*BIN_W  cell histogram, bin 0 in LSBs.
REQ-012 o_valid  output  1  block valid.
REQ-013 o_ready  input  1  downstream accepts block.
REQ-014 bid  output  BID_W  raster block index.
REQ-015 fea_a/fea_b/fea_c/fea_d  output  NBIN*BIN_W each  top-left/top-right/bottom-left/bottom-right cell.

Function
REQ-016 Cell transfer SHALL occur when i_valid && i_ready; block transfer SHALL occur when o_valid && o_ready.
REQ-017 i_ready SHALL equal !o_valid || o_ready (single output register, no combinational path from i_valid to o_valid).
REQ-018 Cells SHALL arrive in raster order; counters cx (0..CELLS_X-1) and cy (0..CELLS_Y-1) SHALL advance per accepted cell, cx wrapping to 0 and incrementing cy, both wrapping to 0 after cell (CELLS_X-1, CELLS_Y-1).
REQ-019 An accepted cell with i_sof=1 SHALL be treated as cell (0,0), regardless of the counter values.
REQ-020 A row buffer of CELLS_X entries SHALL hold the previous row; each accepted cell at cx SHALL read entry cx before overwriting it with i_bin.
REQ-021 Registers SHALL hold the previous cell of the current row (left) and the previous row's entry cx-1 (upper-left).
REQ-022 An accepted cell with cx>=1 and cy>=1 SHALL load, on the same edge, fea_a=upper-left, fea_b=row buffer[cx], fea_c=left, fea_d=i_bin, bid=(cy-1)*(CELLS_X-1)+(cx-1), and set o_valid; latency is 1 cycle.
REQ-023 Cells with cx=0 or cy=0 SHALL be stored only, with no block emitted.
REQ-024 o_valid SHALL clear on a block transfer when no new block is loaded on the same edge; simultaneous transfer and load SHALL keep o_valid=1 with new data.
REQ-025 Outputs SHALL remain stable while o_valid && !o_ready.
REQ-026 Each frame SHALL produce exactly (CELLS_X-1)*(CELLS_Y-1) blocks, bid 0 upward.

Reset
REQ-027 While rst=1: o_valid=0, bid=0, fea_a..fea_d=0, cx=cy=0, left/upper-left registers=0; row buffer contents need not be cleared.
REQ-028 Reset mid-frame SHALL discard any pending block; the next accepted cell is (0,0).

Configuration
REQ-029 With HOG_BLOCK_OVF_EN defined: output o_ovf (1 bit), sticky, set when i_valid=1 && i_ready=0 for 64 consecutive cycles, cleared only by rst.
REQ-030 Without HOG_BLOCK_OVF_EN: o_ovf port and stall counter SHALL not exist.

Structure
REQ-031 NBIN/BIN_W defaults and the bid computation function SHALL live in shared package hog_pkg.
REQ-032 The row buffer SHALL be sub-module hog_line_buf (depth CELLS_X, width NBIN*BIN_W, 1 read + 1 write, read-before-write).

Verification
REQ-033 CELLS_X=4, CELLS_Y=3, o_ready=1, cells with i_bin=cell index -> 6 blocks, bid 0..5; bid 0 has fea_a=0, fea_b=1, fea_c=4, fea_d=5.
REQ-034 o_ready held 0 after first block -> i_ready=0, block 0 stable; o_ready released -> blocks 1..5 in order, none lost.
REQ-035 Two back-to-back frames, second flagged by i_sof -> second frame bid restarts at 0, 12 blocks total.
REQ-036 i_sof asserted at cell 7 of a frame -> counters resync, next block bid 0 after 5 more cells.
REQ-037 rst pulsed with o_valid=1 -> o_valid=0 next cycle, all outputs 0.
REQ-038 HOG_BLOCK_OVF_EN, i_valid=1, o_ready=0 for 64 cycles -> o_ovf=1, held until rst.
